// File: rtl/data_mem_responder_pkg.sv
// Shared types for the data-memory responder: FSM state encoding and wait counter width.
package data_mem_responder_pkg;

    localparam int CNT_W = 4;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_WAIT = 2'd1;
    localparam state_t S_RESP = 2'd2;

endpackage

// File: rtl/data_mem_responder_word_ram.sv
// Word storage array: synchronous write, registered synchronous read.
// Contents are not reset; the read register only updates when i_re is high.
module word_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder: one request at a time, WAIT_STATES+1 cycles accept-to-response,
// response held stable under rsp_ready backpressure; requests refused outside IDLE.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [31:0]           i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                  o_rsp_err
);

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_we;
    logic                  r_err;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic                  w_access;
    logic                  w_ram_we;
    logic                  w_ram_re;
    logic                  w_req_err;
    logic [DATA_WIDTH-1:0] w_ram_rdata;

    // Reset on the access edge must abort the access, so the array strobes are gated by it.
    assign w_access  = (r_state == S_WAIT) && (r_cnt == '0) && !i_reset;
    assign w_ram_we  = w_access &&  r_we && !r_err;
    assign w_ram_re  = w_access && !r_we && !r_err;
    assign w_req_err = |i_req_addr[31:ADDR_WIDTH];

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_state <= S_WAIT;
                        r_cnt   <= CNT_W'(WAIT_STATES);
                        r_we    <= i_req_we;
                        r_err   <= w_req_err;
                        r_addr  <= i_req_addr[ADDR_WIDTH-1:0];
                        r_wdata <= i_req_wdata;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    if (i_rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    word_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_word_ram (
        .i_clk   (i_clock),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_addr  (r_addr),
        .i_wdata (r_wdata),
        .o_rdata (w_ram_rdata)
    );

    // The RAM read register holds its value through RESP; writes and errors force zero data.
    assign o_req_ready = (r_state == S_IDLE);
    assign o_rsp_valid = (r_state == S_RESP);
    assign o_rsp_err   = (r_state == S_RESP) && r_err;
    assign o_rsp_rdata = ((r_state == S_RESP) && !r_we && !r_err) ? w_ram_rdata : '0;

endmodule
